// File: rtl/umi_router_pkg.sv
// Shared state encoding and constants for the UMI address router.
package umi_router_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int CNT_W          = 32;
  localparam int DEFAULT_SELBIT = 40;

endpackage

// File: rtl/umi_addr_decode.sv
// Decodes the port-index field of a destination address into a one-hot select.
module umi_addr_decode
  import umi_router_pkg::*;
#(
  parameter int M      = 4,
  parameter int AW     = 64,
  parameter int SELBIT = DEFAULT_SELBIT
) (
  input  logic [AW-1:0] addr,
  output logic [M-1:0]  sel
);

  localparam int SW = $clog2(M);

  logic [SW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr[SELBIT +: SW];
  // Only the index field matters; the remaining address bits are intentionally ignored.
  assign unused_addr = ^addr;

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

endmodule

// File: rtl/umi_addr_router.sv
// Two-entry skid buffer that tags each UMI transaction with a one-hot port select.
// Optional per-port transfer counters are enabled by defining UMI_ADDR_ROUTER_CNT_EN.
module umi_addr_router
  import umi_router_pkg::*;
#(
  parameter int M      = 4,
  parameter int DW     = 256,
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int SELBIT = DEFAULT_SELBIT
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               umi_in_valid,
  input  logic [CW-1:0]      umi_in_cmd,
  input  logic [AW-1:0]      umi_in_dstaddr,
  input  logic [AW-1:0]      umi_in_srcaddr,
  input  logic [DW-1:0]      umi_in_data,
  output logic               umi_in_ready,
  output logic               umi_out_valid,
  output logic [CW-1:0]      umi_out_cmd,
  output logic [AW-1:0]      umi_out_dstaddr,
  output logic [AW-1:0]      umi_out_srcaddr,
  output logic [DW-1:0]      umi_out_data,
  output logic [M-1:0]       umi_out_select,
  input  logic               umi_out_ready,
  input  logic               cnt_clear,
  output logic [M*CNT_W-1:0] cnt
);

  if (M < 2 || (M & (M - 1)) != 0) begin : g_bad_m
    $error("umi_addr_router: M must be a power of two and at least 2");
  end

  localparam int EW = CW + 2 * AW + DW + M;

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          valid_q, valid_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] skid_q, skid_d;
  logic [EW-1:0] in_entry;
  logic [M-1:0]  in_sel;
  logic [M-1:0]  head_sel;
  logic          in_xfer;
  logic          out_xfer;

  umi_addr_decode #(
    .M      (M),
    .AW     (AW),
    .SELBIT (SELBIT)
  ) u_decode (
    .addr (umi_in_dstaddr),
    .sel  (in_sel)
  );

  assign in_xfer  = umi_in_valid & in_ready_q;
  assign out_xfer = valid_q & umi_out_ready;
  assign in_entry = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data, in_sel};

  // The head slot always holds the oldest entry; the skid slot only fills when output stalls.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = in_entry;
        end else if (in_xfer) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
    valid_d    = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data, head_sel} = head_q;
  assign umi_out_select = valid_q ? head_sel : '0;
  assign umi_out_valid  = valid_q;
  assign umi_in_ready   = in_ready_q;

`ifdef UMI_ADDR_ROUTER_CNT_EN
  logic [CNT_W-1:0] cnt_q [M];
  logic [CNT_W-1:0] cnt_d [M];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear) begin
        cnt_d[i] = '0;
      end else if (out_xfer && umi_out_select[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      if (!nreset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_cnt
    assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  logic unused_cnt_clear;

  assign unused_cnt_clear = cnt_clear;
  assign cnt              = '0;
`endif

endmodule
